// File: rtl/fetch_predictor_if.sv
// Fetch-side bus between the fetch stage and the branch/return predictor.
// The master drives the fetched word and the Execute training feedback; the slave returns the prediction.
interface fetch_predictor_if;
  logic        StallF;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        UpdateE;
  logic [31:0] UpdatePCE;
  logic        UpdateTakenE;
  logic        JumpF;
  logic        IsBranchF;
  logic        IsReturnF;
  logic        PredTakenF;
  logic [31:0] PredPCF;

  modport master (
    output StallF, instrF, PCF, PCPlus4F, UpdateE, UpdatePCE, UpdateTakenE,
    input  JumpF, IsBranchF, IsReturnF, PredTakenF, PredPCF
  );

  modport slave (
    input  StallF, instrF, PCF, PCPlus4F, UpdateE, UpdatePCE, UpdateTakenE,
    output JumpF, IsBranchF, IsReturnF, PredTakenF, PredPCF
  );
endinterface

// File: rtl/fetch_predictor.sv
// Fetch pre-decoder with 2-bit counter branch prediction and an optional return-address stack.
// Define FETCH_PRD_RAS_EN to build the RAS; otherwise returns are decoded but never predicted.
module fetch_predictor #(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input logic              clk,
  input logic              reset_n,
  fetch_predictor_if.slave bus
);
  localparam int unsigned BHT_N = 1 << BHT_IDX_W;

  logic [5:0]  op;
  logic        is_j;
  logic        is_jal;
  logic        is_br;
  logic        is_ret;
  logic [31:0] jump_tgt;
  logic [31:0] br_tgt;
  logic        bht_taken;
  logic        ras_valid;
  logic [31:0] ras_top;
  logic        sel_taken;
  logic [31:0] sel_tgt;

  assign op     = bus.instrF[31:26];
  assign is_j   = (op == 6'b000010);
  assign is_jal = (op == 6'b000011);
  assign is_br  = (op == 6'b000100) || (op == 6'b000101);
  assign is_ret = (op == 6'b000000) && (bus.instrF[25:21] == 5'b11111)
                  && (bus.instrF[5:0] == 6'b001000);

  assign bus.JumpF     = is_j | is_jal;
  assign bus.IsBranchF = is_br;
  assign bus.IsReturnF = is_ret;

  assign jump_tgt = {bus.PCPlus4F[31:28], bus.instrF[25:0], 2'b00};
  assign br_tgt   = bus.PCPlus4F + {{14{bus.instrF[15]}}, bus.instrF[15:0], 2'b00};

  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic [1:0]           cnt_rd [BHT_N];

  assign rd_idx = bus.PCF[BHT_IDX_W+1:2];
  assign wr_idx = bus.UpdatePCE[BHT_IDX_W+1:2];

  // Counters live in flops: the whole table must clear asynchronously and be read in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < BHT_N; gi++) begin : g_bht
      logic [1:0] cnt_q;
      logic [1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (bus.UpdateE && (wr_idx == BHT_IDX_W'(gi))) begin
          if (bus.UpdateTakenE) begin
            if (cnt_q != 2'b11) cnt_d = cnt_q + 2'b01;
          end else if (cnt_q != 2'b00) begin
            cnt_d = cnt_q - 2'b01;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= CNT_INIT;
        else          cnt_q <= cnt_d;
      end

      assign cnt_rd[gi] = cnt_q;
    end
  endgenerate

  assign bht_taken = cnt_rd[rd_idx][1];

`ifdef FETCH_PRD_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] top_d;
  logic [PTR_W-1:0] push_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      ras_mem [RAS_DEPTH];
  logic             push;
  logic             pop;

  assign push     = is_jal & ~bus.StallF;
  assign pop      = is_ret & ~bus.StallF & (count_q != '0);
  assign push_ptr = top_q + PTR_W'(1);

  // A push onto a full stack wraps the pointer over the oldest entry; count just saturates.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (push) begin
      top_d = push_ptr;
      if (count_q != CNT_W'(RAS_DEPTH)) count_d = count_q + CNT_W'(1);
    end else if (pop) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && reset_n) ras_mem[push_ptr] <= bus.PCPlus4F;
  end

  assign ras_valid = (count_q != '0);
  assign ras_top   = ras_mem[top_q];
`else
  logic unused_stall;
  assign unused_stall = bus.StallF;
  assign ras_valid    = 1'b0;
  assign ras_top      = '0;
`endif

  always_comb begin
    sel_taken = 1'b0;
    sel_tgt   = bus.PCPlus4F;
    if (is_j | is_jal) begin
      sel_taken = 1'b1;
      sel_tgt   = jump_tgt;
    end else if (is_br) begin
      sel_taken = bht_taken;
      sel_tgt   = br_tgt;
    end else if (is_ret) begin
      sel_taken = ras_valid;
      sel_tgt   = ras_top;
    end
  end

  assign bus.PredTakenF = sel_taken;
  assign bus.PredPCF    = sel_taken ? sel_tgt : bus.PCPlus4F;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.PCF[31:BHT_IDX_W+2], bus.PCF[1:0],
                            bus.UpdatePCE[31:BHT_IDX_W+2], bus.UpdatePCE[1:0]};
endmodule

// File: tb/tb_fetch_predictor.sv
// Self-checking bench for fetch_predictor: vector table, hand sequences, and randomized traffic vs. a queue-based model.
// Honours FETCH_PRD_RAS_EN the same way as the design.
module tb_fetch_predictor;
  localparam int BHT_N     = 64;
  localparam int RAS_DEPTH = 4;
`ifdef FETCH_PRD_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  fetch_predictor_if bus ();

  fetch_predictor #(.BHT_IDX_W(6), .RAS_DEPTH(RAS_DEPTH), .CNT_INIT(2'b01)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain integer counters and a queue whose back is the newest return address.
  int          bht [BHT_N];
  logic [31:0] ras [$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        upd;
    logic        upd_taken;
    logic [31:0] upd_pc;
    logic        ej;
    logic        eb;
    logic        er;
    logic        et;
    logic [31:0] epc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] instr, pc, input logic upd, tk,
                              input logic [31:0] upd_pc, input logic ej, eb, er, et,
                              input logic [31:0] epc);
    vec_t v;
    v.instr = instr; v.pc = pc; v.upd = upd; v.upd_taken = tk; v.upd_pc = upd_pc;
    v.ej = ej; v.eb = eb; v.er = er; v.et = et; v.epc = epc;
    return v;
  endfunction

  function automatic bit is_ret(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[25:21] == 5'd31) && (ins[5:0] == 6'd8);
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(BHT_N));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_N; i++) bht[i] = 1;
    ras.delete();
  endtask

  task automatic model_update();
    int i;
    if (bus.UpdateE) begin
      i = idx_of(bus.UpdatePCE);
      if (bus.UpdateTakenE) begin
        if (bht[i] < 3) bht[i]++;
      end else if (bht[i] > 0) begin
        bht[i]--;
      end
    end
    if (RAS_ON && !bus.StallF) begin
      if (bus.instrF[31:26] == 6'd3) begin
        ras.push_back(bus.PCPlus4F);
        if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
      end else if (is_ret(bus.instrF) && ras.size() > 0) begin
        void'(ras.pop_back());
      end
    end
  endtask

  task automatic predict(output logic ej, eb, er, et, output logic [31:0] epc);
    logic [31:0] ins;
    logic [31:0] p4;
    int          imm;
    ins = bus.instrF;
    p4  = bus.PCPlus4F;
    ej  = (ins[31:26] == 6'd2) || (ins[31:26] == 6'd3);
    eb  = (ins[31:26] == 6'd4) || (ins[31:26] == 6'd5);
    er  = is_ret(ins);
    et  = 1'b0;
    epc = p4;
    if (ej) begin
      et  = 1'b1;
      epc = (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    end else if (eb) begin
      et  = (bht[idx_of(bus.PCF)] >= 2);
      imm = int'($signed(ins[15:0]));
      if (et) epc = p4 + 32'(imm * 4);
    end else if (er) begin
      et = RAS_ON && (ras.size() > 0);
      if (et) epc = ras[$];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] instr, pc, input logic stall, upd, tk,
                       input logic [31:0] upd_pc);
    bus.instrF       = instr;
    bus.PCF          = pc;
    bus.PCPlus4F     = pc + 32'd4;
    bus.StallF       = stall;
    bus.UpdateE      = upd;
    bus.UpdateTakenE = tk;
    bus.UpdatePCE    = upd_pc;
  endtask

  task automatic look(input string tag, input logic ej, eb, er, et, input logic [31:0] epc);
    #1;
    check({tag, ".JumpF"},      32'(bus.JumpF),      32'(ej));
    check({tag, ".IsBranchF"},  32'(bus.IsBranchF),  32'(eb));
    check({tag, ".IsReturnF"},  32'(bus.IsReturnF),  32'(er));
    check({tag, ".PredTakenF"}, 32'(bus.PredTakenF), 32'(et));
    check({tag, ".PredPCF"},    bus.PredPCF,         epc);
    $display("txn %s rst_n=%b instr=%h pc=%h stall=%b upd=%b/%b@%h -> j=%b b=%b r=%b t=%b pc=%h",
             tag, reset_n, bus.instrF, bus.PCF, bus.StallF, bus.UpdateE, bus.UpdateTakenE,
             bus.UpdatePCE, bus.JumpF, bus.IsBranchF, bus.IsReturnF, bus.PredTakenF, bus.PredPCF);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_update();
    @(negedge clk);
  endtask

  localparam logic [31:0] BEQ_M4 = 32'h1000_FFFC;
  localparam logic [31:0] PC_B   = 32'h0040_0010;
  localparam logic [31:0] JR_RA  = 32'h03E0_0008;
  localparam logic [31:0] ALU    = 32'h0085_1020;

  initial begin
    logic        ej, eb, er, et, stall, upd, tk;
    logic [31:0] epc, instr, pc, upd_pc;
    int          cls;

    checks   = 0;
    failures = 0;
    model_reset();

    vecs[0]  = mk(BEQ_M4, PC_B, 1, 1, PC_B, 0, 1, 0, 0, 32'h0040_0014);
    vecs[1]  = mk(BEQ_M4, PC_B, 1, 1, PC_B, 0, 1, 0, 1, 32'h0040_0004);
    vecs[2]  = mk(BEQ_M4, PC_B, 1, 1, PC_B, 0, 1, 0, 1, 32'h0040_0004);
    vecs[3]  = mk(BEQ_M4, PC_B, 1, 1, PC_B, 0, 1, 0, 1, 32'h0040_0004);
    vecs[4]  = mk(BEQ_M4, PC_B, 1, 0, PC_B, 0, 1, 0, 1, 32'h0040_0004);
    vecs[5]  = mk(BEQ_M4, PC_B, 1, 0, PC_B, 0, 1, 0, 1, 32'h0040_0004);
    vecs[6]  = mk(BEQ_M4, PC_B, 1, 0, PC_B, 0, 1, 0, 0, 32'h0040_0014);
    vecs[7]  = mk(BEQ_M4, PC_B, 1, 0, PC_B, 0, 1, 0, 0, 32'h0040_0014);
    vecs[8]  = mk(BEQ_M4, PC_B, 1, 0, PC_B, 0, 1, 0, 0, 32'h0040_0014);
    vecs[9]  = mk(BEQ_M4, PC_B, 1, 1, PC_B, 0, 1, 0, 0, 32'h0040_0014);
    vecs[10] = mk(BEQ_M4, PC_B, 1, 1, PC_B, 0, 1, 0, 0, 32'h0040_0014);
    vecs[11] = mk(32'h1400_0003, 32'h0040_0110, 0, 0, 0, 0, 1, 0, 1, 32'h0040_0120);
    vecs[12] = mk(32'h1000_0001, 32'h0040_0014, 0, 0, 0, 0, 1, 0, 0, 32'h0040_0018);
    vecs[13] = mk(32'h0BFF_FFFF, 32'hF000_0000, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    vecs[14] = mk(ALU,           32'h0040_0030, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0034);
    vecs[15] = mk(JR_RA,         32'h0040_0040, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0044);
    vecs[16] = mk(32'h0100_0008, 32'h0040_0050, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0054);
    vecs[17] = mk(32'h0C10_0004, 32'h0040_0000, 0, 0, 0, 1, 0, 0, 1, 32'h0040_0010);
    vecs[18] = mk(JR_RA,         32'h0040_0010, 0, 0, 0, 0, 0, 1, RAS_ON,
                  RAS_ON ? 32'h0040_0004 : 32'h0040_0014);
    vecs[19] = mk(JR_RA,         32'h0040_0004, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0008);
    vecs[20] = mk(32'h0810_0000, 32'h0040_0100, 1, 1, 32'h0040_0014, 1, 0, 0, 1, 32'h0040_0000);
    vecs[21] = mk(32'h1000_0001, 32'h0040_0014, 0, 0, 0, 0, 1, 0, 1, 32'h0040_001C);

    // Outputs while held in reset
    reset_n = 1'b0;
    drive(BEQ_M4, PC_B, 0, 0, 0, 0);
    look("rst_beq", 0, 1, 0, 0, 32'h0040_0014);
    drive(32'h0810_0000, 32'h0000_0000, 0, 0, 0, 0);
    look("rst_j", 1, 0, 0, 1, 32'h0040_0000);
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].instr, vecs[i].pc, 1'b0, vecs[i].upd, vecs[i].upd_taken, vecs[i].upd_pc);
      look($sformatf("vec%0d", i), vecs[i].ej, vecs[i].eb, vecs[i].er, vecs[i].et, vecs[i].epc);
      tick();
    end

    // Five calls into a four-deep stack, then five returns
    for (int k = 0; k < 5; k++) begin
      drive({6'h03, 26'(k)}, 32'h0040_1000 + 32'(k) * 32'h100, 0, 0, 0, 0);
      look($sformatf("push%0d", k), 1, 0, 0, 1, 32'(k) * 32'd4);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      et  = RAS_ON && (k < 4);
      epc = et ? (32'h0040_1004 + 32'(4 - k) * 32'h100) : (32'h0040_2004 + 32'(k * 16));
      drive(JR_RA, 32'h0040_2000 + 32'(k * 16), 0, 0, 0, 0);
      look($sformatf("pop%0d", k), 0, 0, 1, et, epc);
      tick();
    end

    // Stalled call pushes once; stalled return does not pop
    for (int k = 0; k < 3; k++) begin
      drive(32'h0C00_0010, 32'h0040_3000, (k < 2), 0, 0, 0);
      look($sformatf("stall_jal%0d", k), 1, 0, 0, 1, 32'h0000_0040);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      et  = RAS_ON && (k < 3);
      epc = et ? 32'h0040_3004 : 32'h0040_3104;
      drive(JR_RA, 32'h0040_3100, (k < 2), 0, 0, 0);
      look($sformatf("stall_jr%0d", k), 0, 0, 1, et, epc);
      tick();
    end

    // Asynchronous reset mid-sequence, no clock edge in between
    for (int k = 0; k < 3; k++) begin
      drive(ALU, 32'h0040_0300, 0, 1, 1, 32'h0040_0200);
      look($sformatf("train%0d", k), 0, 0, 0, 0, 32'h0040_0304);
      tick();
    end
    drive(32'h0C00_0020, 32'h0040_4000, 0, 0, 0, 0);
    look("pre_rst_jal", 1, 0, 0, 1, 32'h0000_0080);
    tick();
    drive(32'h1000_0002, 32'h0040_0200, 0, 0, 0, 0);
    look("pre_rst_beq", 0, 1, 0, 1, 32'h0040_020C);
    reset_n = 1'b0;
    model_reset();
    look("async_rst_beq", 0, 1, 0, 0, 32'h0040_0204);
    drive(JR_RA, 32'h0040_0500, 0, 0, 0, 0);
    look("async_rst_jr", 0, 0, 1, 0, 32'h0040_0504);
    drive(32'h0C00_0020, 32'h0040_4000, 0, 1, 1, 32'h0040_0200);
    look("async_rst_jal", 1, 0, 0, 1, 32'h0000_0080);
    tick();
    reset_n = 1'b1;
    drive(JR_RA, 32'h0040_0500, 0, 0, 0, 0);
    look("post_rst_jr", 0, 0, 1, 0, 32'h0040_0504);
    tick();
    drive(32'h1000_0002, 32'h0040_0200, 0, 0, 0, 0);
    look("post_rst_beq", 0, 1, 0, 0, 32'h0040_0204);
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      cls = int'($urandom_range(0, 9));
      if (n % 16 == 15) pc = 32'hFFFF_FF00 + (32'($urandom_range(0, 63)) << 2);
      else              pc = 32'h0040_0000 + (32'($urandom_range(0, 127)) << 2);
      case (cls)
        0:       instr = {6'h02, 26'($urandom)};
        1, 2:    instr = {6'h03, 26'($urandom)};
        3, 4:    instr = {6'h04, 10'($urandom), 16'($urandom)};
        5:       instr = {6'h05, 10'($urandom), 16'($urandom)};
        6, 7:    instr = JR_RA;
        8:       instr = {6'h00, 5'($urandom_range(0, 30)), 15'h0, 6'h08};
        default: instr = {6'h23, 26'($urandom)};
      endcase
      stall  = ($urandom_range(0, 3) == 0);
      upd    = ($urandom_range(0, 1) == 1);
      tk     = ($urandom_range(0, 2) != 0);
      upd_pc = 32'h0040_0000 + (32'($urandom_range(0, 127)) << 2);
      drive(instr, pc, stall, upd, tk, upd_pc);
      predict(ej, eb, er, et, epc);
      look($sformatf("rnd%0d", n), ej, eb, er, et, epc);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
